// File: rtl/svm_classifier.sv
// One-vs-rest linear SVM over five sensor features plus temperature, one MAC per cycle.
// Optional SVM_NAN_CHECK_EN: a NaN on any sampled input makes UPDATE load 32'hFFFF_FFFF.
module svm_classifier #(
  parameter int unsigned                 NUM_CLASSES = 4,
  parameter logic [NUM_CLASSES*6*32-1:0] WEIGHTS     = '0,
  parameter logic [NUM_CLASSES*32-1:0]   BIAS        = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i0,
  input  logic [31:0] i1,
  input  logic [31:0] i2,
  input  logic [31:0] i3,
  input  logic [31:0] i4,
  input  logic [31:0] temp,
  output logic [31:0] predict
);

  localparam int unsigned   ClsW    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [ClsW-1:0] LastCls = ClsW'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {StSample, StMac, StUpdate} state_e;

  state_e state_q, state_d;
  logic   sample_en, mac_en, update_en;

  logic [ClsW-1:0]    cls_q, cls_d;
  logic [2:0]         feat_q, feat_d;
  logic [191:0]       feats_q, feats_d;
  logic signed [47:0] acc_q, acc_d;
  logic signed [47:0] best_q, best_d;
  logic [ClsW-1:0]    best_idx_q, best_idx_d;
  logic [31:0]        predict_q, predict_d;

  logic signed [31:0] feat_val, weight, bias;
  logic signed [63:0] prod;
  logic signed [47:0] prod_sh;
  int unsigned        pair_idx;

  // Truncate toward zero into Q16.16; NaN -> 0, out of range -> symmetric saturation.
  function automatic logic [31:0] f2q(input logic [31:0] f);
    logic [7:0]  e;
    logic [31:0] sig, mag, res;
    e   = f[30:23];
    sig = {8'd0, 1'b1, f[22:0]};
    mag = '0;
    if (e == 8'd0) begin
      res = '0;
    end else if (e == 8'hFF && f[22:0] != '0) begin
      res = '0;
    end else if (e >= 8'd142) begin
      res = f[31] ? 32'h8000_0001 : 32'h7FFF_FFFF;
    end else begin
      if (e >= 8'd134) mag = sig << (e - 8'd134);
      else             mag = sig >> (8'd134 - e);
      res = f[31] ? (~mag + 32'd1) : mag;
    end
    return res;
  endfunction

`ifdef SVM_NAN_CHECK_EN
  logic nan_q, nan_d;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != '0);
  endfunction
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StSample;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSample: state_d = StMac;
      StMac:    if (feat_q == 3'd5 && cls_q == LastCls) state_d = StUpdate;
      StUpdate: state_d = StSample;
      default:  state_d = StSample;
    endcase
  end

  // FSM: outputs
  always_comb begin
    sample_en = 1'b0;
    mac_en    = 1'b0;
    update_en = 1'b0;
    unique case (state_q)
      StSample: sample_en = 1'b1;
      StMac:    mac_en    = 1'b1;
      StUpdate: update_en = 1'b1;
      default:  sample_en = 1'b0;
    endcase
  end

  always_comb begin
    feats_d    = feats_q;
    cls_d      = cls_q;
    feat_d     = feat_q;
    acc_d      = acc_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    predict_d  = predict_q;

    pair_idx = int'(cls_q) * 6 + int'(feat_q);
    feat_val = feats_q[{feat_q, 5'd0} +: 32];
    weight   = WEIGHTS[pair_idx*32 +: 32];
    bias     = BIAS[int'(cls_q)*32 +: 32];
    prod     = feat_val * weight;
    prod_sh  = 48'(prod >>> 16);

    if (sample_en) begin
      feats_d = {f2q(temp), f2q(i4), f2q(i3), f2q(i2), f2q(i1), f2q(i0)};
      cls_d   = '0;
      feat_d  = '0;
    end

    if (mac_en) begin
      acc_d = ((feat_q == 3'd0) ? {{16{bias[31]}}, bias} : acc_q) + prod_sh;
      if (feat_q == 3'd5) begin
        // Strict compare keeps the lower index on ties.
        if (cls_q == '0 || acc_d > best_q) begin
          best_d     = acc_d;
          best_idx_d = cls_q;
        end
        feat_d = '0;
        cls_d  = (cls_q == LastCls) ? '0 : cls_q + 1'b1;
      end else begin
        feat_d = feat_q + 3'd1;
      end
    end

    if (update_en) predict_d = {{(32-ClsW){1'b0}}, best_idx_q};
`ifdef SVM_NAN_CHECK_EN
    nan_d = nan_q;
    if (sample_en) nan_d = is_nan(i0) | is_nan(i1) | is_nan(i2) | is_nan(i3) | is_nan(i4) |
                           is_nan(temp);
    if (update_en && nan_q) predict_d = 32'hFFFF_FFFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      feats_q    <= '0;
      cls_q      <= '0;
      feat_q     <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      predict_q  <= '0;
`ifdef SVM_NAN_CHECK_EN
      nan_q      <= 1'b0;
`endif
    end else begin
      feats_q    <= feats_d;
      cls_q      <= cls_d;
      feat_q     <= feat_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      predict_q  <= predict_d;
`ifdef SVM_NAN_CHECK_EN
      nan_q      <= nan_d;
`endif
    end
  end

  assign predict = predict_q;

endmodule

// File: tb/tb_svm_classifier.sv
// Directed bench for svm_classifier: four instances with different weight sets share stimulus.
module tb_svm_classifier;

  localparam int unsigned NC = 4;
  localparam logic [NC*6*32-1:0] WA = (NC*6*32)'(32'h0001_0000) << ((2*6+0)*32);
  localparam logic [NC*6*32-1:0] WC = (NC*6*32)'(32'h0001_0000) << ((1*6+5)*32);
  localparam logic [NC*32-1:0]   BB = (NC*32)'(32'h0064_0000) << (3*32);

  // Inputs from the first reference vector
  localparam logic [31:0] A0 = 32'h41163e7c, A1 = 32'h402da481, A2 = 32'h3ee2e70c;
  localparam logic [31:0] A3 = 32'h3f6f4e32, A4 = 32'h40f91bf0, AT = 32'h42c6afb6;
  localparam logic [31:0] NAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i0 = '0, i1 = '0, i2 = '0, i3 = '0, i4 = '0, temp = '0;
  logic [31:0] p_dflt, p_a, p_b, p_c;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  svm_classifier #(.NUM_CLASSES(NC)) u_dflt (
    .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .temp(temp),
    .predict(p_dflt)
  );
  svm_classifier #(.NUM_CLASSES(NC), .WEIGHTS(WA)) u_a (
    .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .temp(temp),
    .predict(p_a)
  );
  svm_classifier #(.NUM_CLASSES(NC), .WEIGHTS(WA), .BIAS(BB)) u_b (
    .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .temp(temp),
    .predict(p_b)
  );
  svm_classifier #(.NUM_CLASSES(NC), .WEIGHTS(WC)) u_c (
    .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .temp(temp),
    .predict(p_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] v0, v1, v2, v3, v4, vt);
    i0 = v0; i1 = v1; i2 = v2; i3 = v3; i4 = v4; temp = vt;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    edges(2);
    check({tag, "/rst_dflt"}, p_dflt, 32'd0);
    check({tag, "/rst_a"}, p_a, 32'd0);
    check({tag, "/rst_b"}, p_b, 32'd0);
    check({tag, "/rst_c"}, p_c, 32'd0);
    rst = 1'b0;
  endtask

  // Apply one vector from reset and check all instances on the first UPDATE edge.
  task automatic run_vec(input string tag, input logic [31:0] v0, v1, v2, v3, v4, vt,
                         input logic [31:0] ea, eb, ec, input bit nan);
    logic [31:0] ed;
    ed = 32'd0;
`ifdef SVM_NAN_CHECK_EN
    if (nan) begin
      ed = 32'hFFFF_FFFF; ea = 32'hFFFF_FFFF; eb = 32'hFFFF_FFFF; ec = 32'hFFFF_FFFF;
    end
`else
    if (nan) ed = 32'd0;
`endif
    set_in(v0, v1, v2, v3, v4, vt);
    do_reset(tag);
    edges(26);
    check({tag, "/dflt"}, p_dflt, ed);
    check({tag, "/a"}, p_a, ea);
    check({tag, "/b"}, p_b, eb);
    check({tag, "/c"}, p_c, ec);
  endtask

  initial begin
    run_vec("ref24",  A0, A1, A2, A3, A4, AT, 2, 3, 1, 1'b0);
    run_vec("ref25",  32'h41b7f93a, 32'h41a61e00, 32'h4155af52, 32'h41871caa, 32'h41f96311,
            32'h424703c9, 2, 3, 1, 1'b0);
    run_vec("t_big",  A0, A1, A2, A3, A4, 32'h49742400, 2, 3, 1, 1'b0);
    run_vec("t_nbig", A0, A1, A2, A3, A4, 32'hC9742400, 2, 3, 0, 1'b0);
    run_vec("neg",    32'hC1163e7c, A1, A2, A3, A4, AT, 0, 3, 1, 1'b0);
    run_vec("tie100", 32'h42C80000, A1, A2, A3, A4, AT, 2, 2, 1, 1'b0);
    run_vec("trunc",  32'h42C7FFFF, A1, A2, A3, A4, AT, 2, 3, 1, 1'b0);
    run_vec("gt100",  32'h42C90000, A1, A2, A3, A4, AT, 2, 2, 1, 1'b0);
    run_vec("lsb_lo", 32'h37000000, A1, A2, A3, A4, AT, 0, 3, 1, 1'b0);
    run_vec("lsb",    32'h37800000, A1, A2, A3, A4, AT, 2, 3, 1, 1'b0);
    run_vec("denorm", 32'h00000001, A1, A2, A3, A4, AT, 0, 3, 1, 1'b0);
    run_vec("pinf",   32'h7F800000, A1, A2, A3, A4, AT, 2, 2, 1, 1'b0);
    run_vec("ninf",   32'hFF800000, A1, A2, A3, A4, AT, 0, 3, 1, 1'b0);
    run_vec("sat",    32'h47000000, A1, A2, A3, A4, AT, 2, 2, 1, 1'b0);
    run_vec("nan_i0", NAN, A1, A2, A3, A4, AT, 0, 3, 1, 1'b1);
    run_vec("nan_i3", A0, A1, A2, NAN, A4, AT, 2, 3, 1, 1'b1);

    // Mid-MAC input change is ignored until the next SAMPLE; predict holds between updates.
    set_in(32'h41b7f93a, 32'h41a61e00, 32'h4155af52, 32'h41871caa, 32'h41f96311, 32'h424703c9);
    do_reset("midmac");
    edges(5);
    i0 = 32'h43480000;
    edges(21);
    check("midmac/frame1", p_b, 32'd3);
    edges(13);
    check("midmac/hold", p_b, 32'd3);
    edges(13);
    check("midmac/frame2", p_b, 32'd2);

    // Reset pulse in the middle of MAC, then first update exactly 26 edges after release.
    set_in(A0, A1, A2, A3, A4, AT);
    do_reset("abort");
    edges(26);
    check("abort/pre", p_a, 32'd2);
    edges(11);
    rst = 1'b1;
    edges(1);
    check("abort/rst", p_a, 32'd0);
    rst = 1'b0;
    edges(25);
    check("abort/edge25", p_a, 32'd0);
    edges(1);
    check("abort/edge26", p_a, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/svm_classifier.md
SVM_CLASSIFIER -- requirements
Module: svm_classifier

Interface
REQ-001 Parameter NUM_CLASSES, default 4: number of one-vs-rest linear classes.
REQ-002 Parameter WEIGHTS, NUM_CLASSES*6*32 bits, default all zero: signed Q16.16 weights; weight (c,f) at bits [(c*6+f)*32 +: 32].
REQ-003 Parameter BIAS, NUM_CLASSES*32 bits, default all zero: signed Q16.16 bias; class c at bits [c*32 +: 32].
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 i0, i1, i2, i3, i4  input  32 each  IEEE-754 single-precision sensor features f0..f4.
REQ-007 temp  input  32  IEEE-754 single-precision temperature, feature f5.
REQ-008 predict  output  32  registered class index, zero-extended.

Function
REQ-009 Operation SHALL be free-running frames of 2+6*NUM_CLASSES cycles (26 at default): SAMPLE (1 cycle), MAC (6*NUM_CLASSES cycles), UPDATE (1 cycle), then back to SAMPLE.
REQ-010 SAMPLE SHALL register all six inputs converted to signed Q16.16; input changes outside SAMPLE SHALL have no effect on the current frame.
REQ-011 Float-to-fixed conversion SHALL truncate toward zero; zero/denormal -> 0; |x| >= 32768 or Inf -> saturate to 32'h7FFF_FFFF / 32'h8000_0001 by sign; NaN -> 0.
REQ-012 MAC SHALL visit pairs in order c=0..NUM_CLASSES-1, f=0..5, one pair per cycle.
REQ-013 The accumulator SHALL be 48-bit signed, loaded with sign-extended BIAS[c] at f=0, then add (feature*weight) full 64-bit signed product arithmetic-shifted right 16, truncated to 48 bits.
REQ-014 At f=5 of class c, the final score SHALL be compared against the running best; class 0 always sets best; a later class replaces it only if strictly greater (ties keep the lower index).
REQ-015 UPDATE SHALL load predict with the best class index; predict SHALL hold its value at all other times.
REQ-016 With default parameters, all scores tie at 0, so predict SHALL become 0 each frame.
REQ-017 No overflow detection SHALL be performed on the 48-bit accumulator (wraps two's complement).

Reset
REQ-018 rst high SHALL force predict = 0, state = SAMPLE, accumulator, best score and best index = 0, and the sampled feature registers = 0.
REQ-019 rst asserted mid-frame SHALL abort the frame with no predict update; the first clock edge with rst low SHALL be SAMPLE, and predict SHALL first update on the 26th edge with rst low (default NUM_CLASSES).
REQ-020 rst and UPDATE coinciding SHALL resolve in favour of reset.

Configuration
REQ-021 Macro SVM_NAN_CHECK_EN defined: SAMPLE SHALL additionally record whether any input is NaN (exponent all ones, mantissa non-zero), and UPDATE SHALL then load predict = 32'hFFFF_FFFF instead of the class index.
REQ-022 Macro SVM_NAN_CHECK_EN undefined: NaN SHALL convert to 0 per REQ-011, with no error code and no extra flag register.

Verification
REQ-023 Default parameters, any inputs, rst high for 2 cycles then low -> predict 0 throughout reset and after every UPDATE.
REQ-024 Weight(2,0)=32'h0001_0000, others 0; i0=32'h41163e7c (9.39), i1=32'h402da481, i2=32'h3ee2e70c, i3=32'h3f6f4e32, i4=32'h40f91bf0, temp=32'h42c6afb6 -> predict 2 on the 26th edge after rst release.
REQ-025 Same weights, BIAS(3)=32'h0064_0000 (100.0); i0=32'h41b7f93a (22.99), i1=32'h41a61e00, i2=32'h4155af52, i3=32'h41871caa, i4=32'h41f96311, temp=32'h424703c9 -> predict 3; i0 changed mid-MAC -> result unchanged that frame.
REQ-026 Weight(1,5)=32'h0001_0000, others 0; temp=32'h49742400 (1e6) -> saturated score, predict 1; temp=32'hC9742400 -> predict 0.
REQ-027 rst pulsed at MAC cycle 10 after predict=2 -> predict 0 next edge, then 2 again exactly 26 edges after release.
REQ-028 SVM_NAN_CHECK_EN defined, i3=32'h7FC0_0000 -> predict 32'hFFFF_FFFF after UPDATE; undefined -> valid class index per REQ-011.
